// File: rtl/ex4_sum_accum.sv
// Windowed accumulator behind the four-operand adder: sums 2^N_LOG2 samples per block
// and presents the saturated total, truncated average and sticky saturation flag.
module ex4_sum_accum #(
  parameter int IN_W   = 6,
  parameter int ACC_W  = 8,
  parameter int N_LOG2 = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic [IN_W-1:0]   in_sum,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [ACC_W-1:0]  out_sum,
  output logic [ACC_W-1:0]  out_avg,
  output logic              out_sat,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [N_LOG2-1:0] sample_cnt
);

  localparam logic [0:0]        ST_ACC   = 1'b0;
  localparam logic [0:0]        ST_DONE  = 1'b1;
  localparam logic [N_LOG2-1:0] CNT_LAST = {N_LOG2{1'b1}};
  localparam logic [N_LOG2-1:0] CNT_ONE  = N_LOG2'(1);
  localparam logic [ACC_W-1:0]  ACC_MAX  = {ACC_W{1'b1}};

  logic [0:0]        state_q, state_d;
  logic [ACC_W-1:0]  acc_q, acc_d;
  logic [N_LOG2-1:0] cnt_q, cnt_d;
  logic              sat_q, sat_d;
  logic              out_valid_q, out_valid_d;
  logic [ACC_W-1:0]  out_sum_q, out_sum_d;
  logic [ACC_W-1:0]  out_avg_q, out_avg_d;
  logic              out_sat_q, out_sat_d;

  logic [ACC_W:0]    add_wide;
  logic              add_sat;
  logic [ACC_W-1:0]  acc_next;

  // One extra bit of headroom makes the overflow test a plain compare.
  always_comb begin
    add_wide = {1'b0, acc_q} + {{(ACC_W + 1 - IN_W){1'b0}}, in_sum};
    add_sat  = (add_wide > {1'b0, ACC_MAX});
    if (add_sat) begin
      acc_next = ACC_MAX;
    end else begin
      acc_next = add_wide[ACC_W-1:0];
    end
  end

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    sat_d       = sat_q;
    out_valid_d = out_valid_q;
    out_sum_d   = out_sum_q;
    out_avg_d   = out_avg_q;
    out_sat_d   = out_sat_q;
    case (state_q)
      ST_ACC: begin
        if (in_valid) begin
          if (cnt_q == CNT_LAST) begin
            out_sum_d   = acc_next;
            out_avg_d   = acc_next >> N_LOG2;
            out_sat_d   = sat_q | add_sat;
            out_valid_d = 1'b1;
            acc_d       = {ACC_W{1'b0}};
            cnt_d       = {N_LOG2{1'b0}};
            sat_d       = 1'b0;
            state_d     = ST_DONE;
          end else begin
            acc_d = acc_next;
            cnt_d = cnt_q + CNT_ONE;
            sat_d = sat_q | add_sat;
          end
        end else begin
          state_d = ST_ACC;
        end
      end
      ST_DONE: begin
        // Results stay on out_* after the handshake; only the valid flag drops.
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = ST_ACC;
        end else begin
          state_d = ST_DONE;
        end
      end
      default: begin
        state_d     = ST_ACC;
        out_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      state_q     <= ST_ACC;
      acc_q       <= {ACC_W{1'b0}};
      cnt_q       <= {N_LOG2{1'b0}};
      sat_q       <= 1'b0;
      out_valid_q <= 1'b0;
      out_sum_q   <= {ACC_W{1'b0}};
      out_avg_q   <= {ACC_W{1'b0}};
      out_sat_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      sat_q       <= sat_d;
      out_valid_q <= out_valid_d;
      out_sum_q   <= out_sum_d;
      out_avg_q   <= out_avg_d;
      out_sat_q   <= out_sat_d;
    end
  end

  assign in_ready   = (state_q == ST_ACC);
  assign out_sum    = out_sum_q;
  assign out_avg    = out_avg_q;
  assign out_sat    = out_sat_q;
  assign out_valid  = out_valid_q;
  assign sample_cnt = cnt_q;

endmodule
